// File: rtl/data_mem_resp.sv
// Word-addressed data memory with fixed-latency single-transaction responses.
// Optional out-of-range error strobe enabled by defining DATA_MEM_OOR_ERR_EN.
module data_mem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wd_i,
    output logic [31:0] mem_rd_o,
    output logic        mem_ready_o,
`ifdef DATA_MEM_OOR_ERR_EN
    output logic        err_o,
`endif
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Handshake: the initiator raises mem_req_i with stable attributes and holds it
    // until mem_ready_o pulses for one cycle; dropping it while waiting aborts the
    // access, and a request seen during the response cycle is ignored.

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wd_q, wd_d;
    logic            oor_q, oor_d;
    logic [31:0]     rd_q, rd_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            in_oor;
    logic            enter_resp;
    logic            acc_we;
    logic [3:0]      acc_be;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wd;
    logic            acc_oor;
    logic            write_en;

`ifdef DATA_MEM_OOR_ERR_EN
    logic [1:0]      addr_unused;
    assign addr_unused = mem_addr_i[1:0];
    assign in_oor      = |mem_addr_i[31:AW+2];
`else
    // Upper address bits are dropped so the index wraps modulo the depth.
    logic [31-AW:0]  addr_unused;
    assign addr_unused = {mem_addr_i[31:AW+2], mem_addr_i[1:0]};
    assign in_oor      = 1'b0;
`endif

    // With zero wait states the access happens on the capture edge, so the
    // live inputs stand in for the not-yet-loaded capture registers.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we  = mem_we_i;
            acc_be  = mem_be_i;
            acc_idx = mem_addr_i[AW+1:2];
            acc_wd  = mem_wd_i;
            acc_oor = in_oor;
        end else begin
            acc_we  = we_q;
            acc_be  = be_q;
            acc_idx = idx_q;
            acc_wd  = wd_q;
            acc_oor = oor_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        be_d       = be_q;
        idx_d      = idx_q;
        wd_d       = wd_q;
        oor_d      = oor_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    we_d  = mem_we_i;
                    be_d  = mem_be_i;
                    idx_d = mem_addr_i[AW+1:2];
                    wd_d  = mem_wd_i;
                    oor_d = in_oor;
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!mem_req_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        rd_d    = rd_q;
        ready_d = enter_resp;
        err_d   = enter_resp && acc_oor;
        if (enter_resp && !acc_we) begin
            rd_d = acc_oor ? 32'h0 : mem_q[acc_idx];
        end
    end

    // Reset gates the write so an edge seen while reset is held cannot commit.
    assign write_en = enter_resp && acc_we && !acc_oor && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            idx_q   <= '0;
            wd_q    <= 32'h0;
            oor_q   <= 1'b0;
            rd_q    <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            oor_q   <= oor_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (write_en) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_be[k]) begin
                    mem_q[acc_idx][8*k +: 8] <= acc_wd[8*k +: 8];
                end
            end
        end
    end

    assign mem_rd_o    = rd_q;
    assign mem_ready_o = ready_q;
    assign dbg_state_o = state_q;
`ifdef DATA_MEM_OOR_ERR_EN
    assign err_o = err_q;
`else
    logic err_unused;
    assign err_unused = err_q;
`endif

endmodule
